// File: rtl/lcd_cmd_seq_if.sv
// Host/controller signal bundle for lcd_cmd_seq.
// Optional feature macro: CMD_CHECK_EN adds the cmd_err strobe.
// slave = sequencer side, master = host/controller (or testbench) side.
interface lcd_cmd_seq_if #(
    parameter int AW = 4
) ();
    logic [3:0]  host_cmd;
    logic        host_push;
    logic        host_full;
    logic [AW:0] fifo_count;
    logic [3:0]  lcd_cmd;
    logic        lcd_cmd_valid;
    logic        lcd_busy;
    logic        lcd_done;
    logic        seq_idle;
    logic        seq_done;
    logic        ovf_err;
    logic        ack_err;
`ifdef CMD_CHECK_EN
    logic        cmd_err;

    modport slave (
        input  host_cmd, host_push, lcd_busy, lcd_done,
        output host_full, fifo_count, lcd_cmd, lcd_cmd_valid,
               seq_idle, seq_done, ovf_err, ack_err, cmd_err
    );
    modport master (
        output host_cmd, host_push, lcd_busy, lcd_done,
        input  host_full, fifo_count, lcd_cmd, lcd_cmd_valid,
               seq_idle, seq_done, ovf_err, ack_err, cmd_err
    );
`else
    modport slave (
        input  host_cmd, host_push, lcd_busy, lcd_done,
        output host_full, fifo_count, lcd_cmd, lcd_cmd_valid,
               seq_idle, seq_done, ovf_err, ack_err
    );
    modport master (
        output host_cmd, host_push, lcd_busy, lcd_done,
        input  host_full, fifo_count, lcd_cmd, lcd_cmd_valid,
               seq_idle, seq_done, ovf_err, ack_err
    );
`endif
endinterface

// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: queues host commands in a FIFO and issues them one
// at a time to the image controller, waiting for busy/done handshakes.
// A WRITE (code 0) ends the run once done is seen.
// Optional feature macro: CMD_CHECK_EN rejects codes above 11 and pulses cmd_err.
module lcd_cmd_seq #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int ACK_TO = 4
) (
    input  logic          clk,
    input  logic          reset,
    lcd_cmd_seq_if.slave  bus
);
    localparam int TW = $clog2(ACK_TO) + 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ACK, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count_q, count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      cur_cmd;
    logic            push_ok, pop, issue, ack_fail, cmd_bad;
    logic            full_q, valid_q, idle_q, done_q, ovf_q, ack_q;
    logic [3:0]      lcd_cmd_q;

`ifdef CMD_CHECK_EN
    logic            cmd_err_q;
    assign cmd_bad     = (bus.host_cmd > 4'd11);
    assign bus.cmd_err = cmd_err_q;

    // One-cycle strobe for every rejected out-of-range push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cmd_err_q <= 1'b0;
        else       cmd_err_q <= bus.host_push && cmd_bad;
    end
`else
    assign cmd_bad = 1'b0;
`endif

    assign push_ok           = bus.host_push && !full_q && !cmd_bad;
    assign bus.host_full     = full_q;
    assign bus.fifo_count    = count_q;
    assign bus.lcd_cmd       = lcd_cmd_q;
    assign bus.lcd_cmd_valid = valid_q;
    assign bus.seq_idle      = idle_q;
    assign bus.seq_done      = done_q;
    assign bus.ovf_err       = ovf_q;
    assign bus.ack_err       = ack_q;

    // Next occupancy from accepted push and FSM pop
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + (AW+1)'(1);
        else if (!push_ok && pop) count_d = count_q - (AW+1)'(1);
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus.host_cmd;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_d;
        end
    end

    // FSM state and acknowledge timer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pop      = 1'b0;
        issue    = 1'b0;
        ack_fail = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0 && !bus.lcd_busy) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // Busy rising during the issue cycle defers the strobe, so a
                // strobe never follows a cycle with busy high.
                if (bus.lcd_busy) begin
                    state_d = S_IDLE;
                end else begin
                    issue   = 1'b1;
                    pop     = 1'b1;
                    timer_d = '0;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (bus.lcd_busy) begin
                    state_d = S_RUN;
                end else if (timer_q == TW'(ACK_TO - 1)) begin
                    ack_fail = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RUN: begin
                if (!bus.lcd_busy) begin
                    if (cur_cmd != 4'd0)   state_d = S_IDLE;
                    else if (bus.lcd_done) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs and sticky error/status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lcd_cmd_q <= '0;
            cur_cmd   <= '0;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            idle_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            valid_q <= issue;
            if (issue) begin
                lcd_cmd_q <= mem[rd_ptr];
                cur_cmd   <= mem[rd_ptr];
            end
            full_q <= (count_d == (AW+1)'(DEPTH));
            idle_q <= (state_d == S_IDLE) && (count_d == '0);
            if (state_d == S_DONE)                        done_q <= 1'b1;
            if (bus.host_push && full_q && !cmd_bad)      ovf_q  <= 1'b1;
            if (ack_fail)                                 ack_q  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed testbench for lcd_cmd_seq; optional CMD_CHECK_EN section
// exercises range checking when that macro is defined.
module tb_lcd_cmd_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   strobes = 0;
    logic [3:0] log_q[$];

    lcd_cmd_seq_if #(.AW(4)) bus ();

    lcd_cmd_seq #(.DEPTH(16), .AW(4), .ACK_TO(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Record every strobe; a strobe lasting two cycles is logged twice
    always @(negedge clk) begin
        if (bus.lcd_cmd_valid === 1'b1) begin
            strobes++;
            log_q.push_back(bus.lcd_cmd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset         = 1'b1;
        bus.host_push = 1'b0;
        bus.host_cmd  = 4'd0;
        bus.lcd_busy  = 1'b0;
        bus.lcd_done  = 1'b0;
        #2;
        check("rst_count", bus.fifo_count, 0);
        check("rst_full",  bus.host_full, 0);
        check("rst_valid", bus.lcd_cmd_valid, 0);
        check("rst_cmd",   bus.lcd_cmd, 0);
        check("rst_idle",  bus.seq_idle, 0);
        check("rst_done",  bus.seq_done, 0);
        check("rst_ovf",   bus.ovf_err, 0);
        check("rst_ack",   bus.ack_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push(input logic [3:0] code);
        bus.host_cmd  = code;
        bus.host_push = 1'b1;
        step();
        bus.host_push = 1'b0;
    endtask

    // Wait for a strobe, check its code, then play the controller busy/done
    task automatic serve(input logic [3:0] code, input int busy_cyc, input bit with_done);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (bus.lcd_cmd_valid === 1'b1) seen = 1'b1;
        end
        check("strobe_seen", 32'(seen), 1);
        if (seen) check("strobe_code", bus.lcd_cmd, code);
        bus.lcd_busy = 1'b1;
        step(busy_cyc);
        bus.lcd_busy = 1'b0;
        if (with_done) begin
            bus.lcd_done = 1'b1;
            step();
            bus.lcd_done = 1'b0;
        end
        step();
    endtask

    initial begin
        int base;
        logic [3:0] exp_q[$];

        // Image-load busy holds off issue; then 1 and 5 in order
        apply_reset();
        bus.lcd_busy = 1'b1;
        push(4'd1);
        push(4'd5);
        check("t1_count", bus.fifo_count, 2);
        base = strobes;
        step(68);
        check("t1_no_strobe", strobes - base, 0);
        check("t1_not_idle", bus.seq_idle, 0);
        bus.lcd_busy = 1'b0;
        serve(4'd1, 3, 1'b0);
        serve(4'd5, 3, 1'b0);
        check("t1_strobes", strobes - base, 2);
        check("t1_first",  log_q[base], 1);
        check("t1_second", log_q[base + 1], 5);
        check("t1_idle", bus.seq_idle, 1);

        // Fill FIFO with busy stuck, overflow, then drain with pointer wrap
        apply_reset();
        bus.lcd_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(4'((i % 11) + 1));
            exp_q.push_back(4'((i % 11) + 1));
            if (i == 14) begin
                check("t2_count15", bus.fifo_count, 15);
                check("t2_notfull15", bus.host_full, 0);
            end
        end
        check("t2_count16", bus.fifo_count, 16);
        check("t2_full16", bus.host_full, 1);
        check("t2_ovf_pre", bus.ovf_err, 0);
        push(4'd7);
        check("t2_ovf", bus.ovf_err, 1);
        check("t2_count_ovf", bus.fifo_count, 16);
        check("t2_full_ovf", bus.host_full, 1);
        bus.lcd_busy = 1'b0;
        serve(exp_q.pop_front(), 1, 1'b0);
        push(4'd9);
        exp_q.push_back(4'd9);
        while (exp_q.size() > 0) serve(exp_q.pop_front(), 1, 1'b0);
        check("t2_drained", bus.fifo_count, 0);
        check("t2_idle", bus.seq_idle, 1);

        // Latency and single-cycle strobe with one-cycle busy pulse
        apply_reset();
        push(4'd3);
        step();
        check("t3_valid_e1", bus.lcd_cmd_valid, 0);
        step();
        check("t3_valid_e2", bus.lcd_cmd_valid, 1);
        check("t3_cmd", bus.lcd_cmd, 3);
        bus.lcd_busy = 1'b1;
        step();
        check("t3_valid_e3", bus.lcd_cmd_valid, 0);
        check("t3_idle_e3", bus.seq_idle, 0);
        bus.lcd_busy = 1'b0;
        step();
        check("t3_idle_e4", bus.seq_idle, 1);

        // Acknowledge timeout, then next queued command still issues
        apply_reset();
        push(4'd6);
        push(4'd7);
        step();
        check("t4_strobe", bus.lcd_cmd_valid, 1);
        check("t4_cmd", bus.lcd_cmd, 6);
        step(3);
        check("t4_ack_pre", bus.ack_err, 0);
        step();
        check("t4_ack", bus.ack_err, 1);
        serve(4'd7, 2, 1'b0);
        check("t4_ack_sticky", bus.ack_err, 1);

`ifndef CMD_CHECK_EN
        // Undefined codes pass through unchanged as ordinary commands
        apply_reset();
        push(4'd13);
        serve(4'd13, 2, 1'b0);
        check("t6_pass_idle", bus.seq_idle, 1);
`endif

        // WRITE completes, sequencer halts and ignores later commands
        apply_reset();
        push(4'd0);
        serve(4'd0, 65, 1'b1);
        check("t5_done", bus.seq_done, 1);
        base = strobes;
        push(4'd2);
        step(20);
        check("t5_no_issue", strobes - base, 0);
        check("t5_count", bus.fifo_count, 1);
        check("t5_done_hold", bus.seq_done, 1);

`ifdef CMD_CHECK_EN
        // Out-of-range push rejected with a one-cycle error strobe
        apply_reset();
        bus.lcd_busy = 1'b1;
        push(4'd13);
        check("t7_cmd_err", bus.cmd_err, 1);
        check("t7_count0", bus.fifo_count, 0);
        step();
        check("t7_cmd_err_clr", bus.cmd_err, 0);
        push(4'd11);
        check("t7_count1", bus.fifo_count, 1);
        check("t7_no_err", bus.cmd_err, 0);
`endif

        apply_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
